// File: rtl/rr_mux_pkg.sv
// Shared types and constants for the eight-channel round-robin multiplexer.
// Consumed by rr_arbiter_8 and rr_mux_8to1.
package rr_mux_pkg;
  localparam int N_CH  = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_CH-1:0]  chmask_t;

  // Pointer value after reset, so that the first scan starts at channel 0
  localparam sel_t PTR_RST = sel_t'(N_CH - 1);

  function automatic chmask_t onehot(input sel_t idx);
    return chmask_t'(1) << idx;
  endfunction
endpackage

// File: rtl/rr_arbiter_8.sv
// Combinational round-robin picker: grants the first requester after ptr,
// wrapping 7->0, with ptr itself scanned last.
module rr_arbiter_8
  import rr_mux_pkg::*;
(
  input  chmask_t req,
  input  sel_t    ptr,
  output logic    gnt_v,
  output sel_t    gnt_idx
);

  sel_t w_idx;

  // Scan from the farthest offset down so the nearest requester wins last
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    w_idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      w_idx = ptr + sel_t'(k);
      if (req[w_idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_mux_8to1.sv
// Eight-channel round-robin serialiser with one holding register per channel.
// Optional transfer counter on xfer_count when RR_MUX_STATS_EN is defined.
module rr_mux_8to1 #(
  parameter int DW   = 1,
  parameter int N_CH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*DW-1:0]    in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output rr_mux_pkg::sel_t      out_sel
`ifdef RR_MUX_STATS_EN
  ,
  output logic [15:0]           xfer_count
`endif
);

  import rr_mux_pkg::*;

  chmask_t       r_hold_v;
  logic [DW-1:0] r_hold_d [N_CH];
  sel_t          r_ptr;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  sel_t          r_out_sel;

  logic    w_gnt_v;
  sel_t    w_gnt_idx;
  logic    w_load;
  chmask_t w_accept;
  chmask_t w_clr;

  rr_arbiter_8 u_arb (
    .req     (r_hold_v),
    .ptr     (r_ptr),
    .gnt_v   (w_gnt_v),
    .gnt_idx (w_gnt_idx)
  );

  // A held channel is never ready, so accept and grant never hit the same channel
  assign w_accept = in_valid & ~r_hold_v;
  assign w_load   = w_gnt_v && (!r_out_valid || out_ready);
  assign w_clr    = w_load ? onehot(w_gnt_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_hold_v <= '0;
    else        r_hold_v <= (r_hold_v | w_accept) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (w_accept[i]) r_hold_d[i] <= in_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_ptr       <= PTR_RST;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= r_hold_d[w_gnt_idx];
      r_out_sel   <= w_gnt_idx;
      r_ptr       <= w_gnt_idx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RR_MUX_STATS_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_xfer_count <= '0;
    else if (r_out_valid && out_ready && r_xfer_count != 16'hFFFF)
      r_xfer_count <= r_xfer_count + 16'd1;
  end

  assign xfer_count = r_xfer_count;
`endif

  assign in_ready  = ~r_hold_v;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
